// File: rtl/pwm_core.sv
// PWM core: prescaled period counter with shadowed period/duty/prescale, registered
// compare and output stage. Define PWM_DEADTIME_EN to insert a dead-time gap on each edge.
module pwm_core #(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned DT_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      ctrl,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] duty,
  input  logic [CNT_W-1:0] prescale,
  output logic             pwm_p,
  output logic             pwm_n,
  output logic             period_done,
  output logic [CNT_W-1:0] status
);

  logic             en, pol;
  logic             tick, wrap;
  logic             p_act, n_act;
  logic             unused_ctrl;
  logic [CNT_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] per_sh_q, per_sh_d;
  logic [CNT_W-1:0] duty_sh_q, duty_sh_d;
  logic [CNT_W-1:0] pre_sh_q, pre_sh_d;
  logic             raw_q, raw_d;
  logic             pwm_p_q, pwm_p_d;
  logic             pwm_n_q, pwm_n_d;

  assign en          = ctrl[0];
  assign pol         = ctrl[1];
  assign unused_ctrl = ^ctrl[31:2];

  assign tick = (pre_cnt_q == pre_sh_q);
  assign wrap = tick && (cnt_q == per_sh_q);

  always_comb begin
    pre_cnt_d = '0;
    cnt_d     = '0;
    per_sh_d  = period;
    duty_sh_d = duty;
    pre_sh_d  = prescale;
    raw_d     = 1'b0;
    if (en) begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + CNT_W'(1);
      cnt_d     = cnt_q;
      if (tick) begin
        cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
      end
      // Shadows only follow the inputs at a wrap while running.
      if (!wrap) begin
        per_sh_d  = per_sh_q;
        duty_sh_d = duty_sh_q;
        pre_sh_d  = pre_sh_q;
      end
      raw_d = (cnt_q < duty_sh_q);
    end
  end

`ifdef PWM_DEADTIME_EN
  localparam logic [7:0] DT_LOAD = 8'(DT_CYCLES);

  logic [7:0] dt_cnt_q, dt_cnt_d;
  logic       raw_last_q, raw_last_d;

  // Any raw edge (re)loads the gap; a side may drive only once the count has drained.
  always_comb begin
    dt_cnt_d   = '0;
    raw_last_d = en & raw_q;
    if (en) begin
      if (raw_q != raw_last_q) begin
        dt_cnt_d = DT_LOAD;
      end else if (dt_cnt_q != '0) begin
        dt_cnt_d = dt_cnt_q - 8'd1;
      end
    end
    p_act = en & raw_q & (dt_cnt_d == '0);
    n_act = en & ~raw_q & (dt_cnt_d == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dt_cnt_q   <= '0;
      raw_last_q <= 1'b0;
    end else begin
      dt_cnt_q   <= dt_cnt_d;
      raw_last_q <= raw_last_d;
    end
  end
`else
  localparam int unsigned dt_cycles_unused = DT_CYCLES;

  always_comb begin
    p_act = en & raw_q;
    n_act = en & ~raw_q;
  end
`endif

  always_comb begin
    pwm_p_d = p_act ? ~pol : pol;
    pwm_n_d = n_act ? ~pol : pol;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pre_cnt_q <= '0;
      cnt_q     <= '0;
      per_sh_q  <= '0;
      duty_sh_q <= '0;
      pre_sh_q  <= '0;
      raw_q     <= 1'b0;
      pwm_p_q   <= 1'b0;
      pwm_n_q   <= 1'b0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      cnt_q     <= cnt_d;
      per_sh_q  <= per_sh_d;
      duty_sh_q <= duty_sh_d;
      pre_sh_q  <= pre_sh_d;
      raw_q     <= raw_d;
      pwm_p_q   <= pwm_p_d;
      pwm_n_q   <= pwm_n_d;
    end
  end

  assign pwm_p       = pwm_p_q;
  assign pwm_n       = pwm_n_q;
  assign status      = cnt_q;
  assign period_done = en & wrap & ~reset;

endmodule

// File: tb/tb_pwm_core.sv
// Bench for pwm_core: position-in-period reference model checked every clock,
// plus literal window counts for the directed scenarios and randomized register traffic.
module tb_pwm_core;

  localparam int unsigned CNT_W = 32;
  localparam int unsigned DT    = 4;

  logic             clock    = 1'b0;
  logic             reset    = 1'b1;
  logic [31:0]      ctrl     = 32'd3;
  logic [CNT_W-1:0] period   = 9;
  logic [CNT_W-1:0] duty     = 3;
  logic [CNT_W-1:0] prescale = 0;
  logic             pwm_p, pwm_n, period_done;
  logic [CNT_W-1:0] status;

  int vectors     = 0;
  int miscompares = 0;

  pwm_core #(.CNT_W(CNT_W), .DT_CYCLES(DT)) dut (
    .clock       (clock),
    .reset       (reset),
    .ctrl        (ctrl),
    .period      (period),
    .duty        (duty),
    .prescale    (prescale),
    .pwm_p       (pwm_p),
    .pwm_n       (pwm_n),
    .period_done (period_done),
    .status      (status)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position in clocks since the start of the current period, with
  // period/duty/prescale latched at period start (or every clock while disabled).
  longint m_pos  = 0;
  longint m_per  = 0;
  longint m_duty = 0;
  longint m_pre  = 0;
  bit     m_raw  = 0;
  bit     m_p    = 0;
  bit     m_n    = 0;
`ifdef PWM_DEADTIME_EN
  bit [DT-1:0] hist = '0;
`endif

  always @(posedge clock) begin
    bit     en, pol, all1, all0, new_raw;
    longint len;
    en  = ctrl[0];
    pol = ctrl[1];
    if (reset) begin
      m_pos = 0; m_per = 0; m_duty = 0; m_pre = 0;
      m_raw = 0; m_p = 0; m_n = 0;
`ifdef PWM_DEADTIME_EN
      hist = '0;
`endif
    end else begin
      all1 = m_raw;
      all0 = !m_raw;
`ifdef PWM_DEADTIME_EN
      all1 = all1 && (&hist);
      all0 = all0 && !(|hist);
      if (en) hist = {hist[DT-2:0], m_raw};
      else    hist = '0;
`endif
      m_p = (en && all1) ? !pol : pol;
      m_n = (en && all0) ? !pol : pol;
      new_raw = en && ((m_pos / (m_pre + 1)) < m_duty);
      len = (m_per + 1) * (m_pre + 1);
      if (!en || m_pos == len - 1) begin
        m_pos = 0; m_per = period; m_duty = duty; m_pre = prescale;
      end else begin
        m_pos++;
      end
      m_raw = new_raw;
    end
    #1;
    check("pwm_p", pwm_p, m_p);
    check("pwm_n", pwm_n, m_n);
    check("period_done", period_done,
          (!reset && ctrl[0] && m_pos == (m_per + 1) * (m_pre + 1) - 1) ? 1 : 0);
    check("status", status, m_pos / (m_pre + 1));
  end

  task automatic window(input int n, output int hp, output int hn, output int pd, output int sc);
    logic [CNT_W-1:0] last;
    hp = 0; hn = 0; pd = 0; sc = 0;
    @(negedge clock);
    last = status;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (pwm_p === 1'b1) hp++;
      if (pwm_n === 1'b1) hn++;
      if (period_done === 1'b1) pd++;
      if (status !== last) sc++;
      last = status;
    end
  endtask

  initial begin
    int hp, hn, pd, sc;
    repeat (3) @(negedge clock);
    check("rst_pwm_p", pwm_p, 0);
    check("rst_pwm_n", pwm_n, 0);
    check("rst_status", status, 0);
    check("rst_done", period_done, 0);

    reset = 1'b0; ctrl = 32'd1; prescale = 0; period = 9;
`ifdef PWM_DEADTIME_EN
    duty = 5;
    repeat (30) @(negedge clock);
    window(20, hp, hn, pd, sc);
    check("dt_p_active", hp, 2);
    check("dt_n_active", hn, 2);
    check("dt_done", pd, 2);
`else
    duty = 3;
    repeat (30) @(negedge clock);
    window(20, hp, hn, pd, sc);
    check("s1_high", hp, 6);
    check("s1_n_high", hn, 14);
    check("s1_done", pd, 2);
`endif

    prescale = 3; period = 4; duty = 2;
    repeat (50) @(negedge clock);
    window(40, hp, hn, pd, sc);
`ifdef PWM_DEADTIME_EN
    check("pre_high", hp, 8);
    check("pre_n_high", hn, 16);
`else
    check("pre_high", hp, 16);
    check("pre_n_high", hn, 24);
`endif
    check("pre_steps", sc, 10);
    check("pre_done", pd, 2);

    prescale = 0; period = 9; duty = 0;
    repeat (40) @(negedge clock);
    window(20, hp, hn, pd, sc);
    check("duty0_high", hp, 0);
    check("duty0_n_high", hn, 20);

    duty = 15;
    repeat (25) @(negedge clock);
    window(20, hp, hn, pd, sc);
    check("duty15_high", hp, 20);
    check("duty15_n_high", hn, 0);

    ctrl = 32'd3; duty = 3;
    repeat (25) @(negedge clock);
    window(20, hp, hn, pd, sc);
`ifdef PWM_DEADTIME_EN
    check("inv_high", hp, 20);
    check("inv_n_high", hn, 14);
`else
    check("inv_high", hp, 14);
    check("inv_n_high", hn, 6);
`endif

    repeat (4) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("midrst_pwm_p", pwm_p, 0);
    check("midrst_pwm_n", pwm_n, 0);
    check("midrst_status", status, 0);
    reset = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if ($urandom_range(0, 39) == 0) period   = $urandom_range(0, 12);
      if ($urandom_range(0, 39) == 0) duty     = $urandom_range(0, 15);
      if ($urandom_range(0, 59) == 0) prescale = $urandom_range(0, 3);
      if ($urandom_range(0, 79) == 0) ctrl[0]  = ~ctrl[0];
      if ($urandom_range(0, 99) == 0) ctrl[1]  = ~ctrl[1];
      if ($urandom_range(0, 49) == 0) ctrl[31:2] = 30'($urandom);
      reset = ($urandom_range(0, 299) == 0);
    end
    reset = 1'b0;
    repeat (3) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pwm_core.md
PWM_CORE -- requirements
Module: pwm_core

Interface
REQ-001 Parameter CNT_W, default 32: width of the period, duty and prescale counters and of the status output.
REQ-002 Parameter DT_CYCLES, default 4: dead-time length in clock cycles; legal range 1..255.
REQ-003 Port clock  in  1: single clock; all state updates on its rising edge.
REQ-004 Port reset  in  1: synchronous, active-high reset.
REQ-005 Port ctrl  in  32: control register. Bit0 is enable, bit1 is polarity (1 inverts the outputs), other bits ignored.
REQ-006 Port period  in  CNT_W: period register; a PWM period is period+1 ticks.
REQ-007 Port duty  in  CNT_W: duty register; number of ticks per period during which the output is active.
REQ-008 Port prescale  in  CNT_W: tick divider; one tick every prescale+1 clocks.
REQ-009 Port pwm_p  out  1: main PWM output.
REQ-010 Port pwm_n  out  1: complementary PWM output.
REQ-011 Port period_done  out  1: one-clock pulse at each period wrap.
REQ-012 Port status  out  CNT_W: current period counter value, for register readback.

Function
REQ-013 Prescaler pre_cnt SHALL count 0..pre_sh; tick=1 when pre_cnt==pre_sh, and pre_cnt returns to 0 on the next clock; pre_sh=0 gives a tick every clock.
REQ-014 Period counter cnt SHALL increment on tick; on a tick with cnt==per_sh it SHALL wrap to 0 and assert period_done for exactly that clock.
REQ-015 Shadow registers per_sh, duty_sh and pre_sh SHALL load from period, duty and prescale at every wrap, and every clock while enable=0; mid-period input changes take effect only at the next wrap.
REQ-016 raw SHALL be registered as (cnt < duty_sh), one clock after cnt; duty_sh=0 keeps raw low; duty_sh>per_sh keeps raw high.
REQ-017 period=0: cnt stays 0, every tick is a wrap; raw=1 iff duty>=1.
REQ-018 enable=0: pre_cnt, cnt and raw held at 0, period_done=0, and pwm_p and pwm_n forced to the inactive level.
REQ-019 Enable 0->1: counting starts from cnt=0 and pre_cnt=0 using the shadows loaded on the last disabled clock.
REQ-020 Active level SHALL be 1 when polarity=0 and 0 when polarity=1; inactive level is its complement.
REQ-021 Output stage (pwm_p, pwm_n) SHALL be registered, adding one clock after raw; nominally pwm_p active iff raw=1 and pwm_n active iff raw=0.
REQ-022 status SHALL equal cnt, combinational from the register.
REQ-023 Simultaneous wrap and enable falling edge: the disable wins; counters go to 0 and period_done=0.

Reset
REQ-024 While reset=1: pre_cnt=0, cnt=0, all shadows=0, raw=0, dead-time counter=0, period_done=0, status=0, and pwm_p=pwm_n=0 regardless of polarity.
REQ-025 After reset deasserts, outputs follow REQ-018..REQ-021 from the first clock.

Configuration
REQ-026 Macro PWM_DEADTIME_EN defined: on every raw edge, pwm_p and pwm_n SHALL both be inactive for DT_CYCLES clocks, after which the new side goes active.
REQ-027 With PWM_DEADTIME_EN defined: a raw edge during dead time SHALL restart the dead-time count. If raw pulses are shorter than DT_CYCLES, neither output goes active.
REQ-028 Macro PWM_DEADTIME_EN undefined: pwm_n SHALL be the exact complement of pwm_p every clock, with no gap; DT_CYCLES ignored.

Verification
REQ-029 Scenario: prescale=0, period=9, duty=3, ctrl=1 -> pwm_p high 3 and low 7 clocks, repeating; period_done every 10 clocks.
REQ-030 Scenario: duty changed 3->6 mid-period -> current period keeps a 3-clock high time; next period high 6 clocks.
REQ-031 Scenario: prescale=3, period=4, duty=2 -> 20-clock period, pwm_p high 8 clocks; status steps every 4 clocks.
REQ-032 Scenario: duty=0 -> pwm_p constant low; duty=15 with period=9 -> pwm_p constant high; ctrl=3 (polarity=1) -> both levels inverted.
REQ-033 Scenario: PWM_DEADTIME_EN defined, DT_CYCLES=4, period=9, duty=5 -> pwm_p active 1 clock; both outputs inactive 4 clocks at each edge; pwm_p and pwm_n never active together.
REQ-034 Scenario: reset=1 pulsed mid-period with ctrl=3 -> outputs 0 during reset; counting restarts from cnt=0 on release.
